// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU memory path.
//   - Load opcode constants (instruction bits [31:26]). The store byte-enable
//     logic reuses the same encoding space.
//   - Load unit state encoding.
//   - is_load_op(): true for the load opcodes the load unit accepts.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_load_op(input logic [5:0] op);
      logic ok;
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational lane select and sign/zero extension for loads. Lanes are
// little-endian and match the store byte-enable lanes.
// Ports:
//   op_i        load opcode
//   lane_i      byte address bits [1:0]
//   word_i      32-bit word read from memory
//   data_o      extended load value
//   misalign_o  halfword on odd address, or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module load_extract
   import cpu_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o,
   output logic        misalign_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word_i[7:0];
      case (lane_i)
         2'd0:    byte_v = word_i[7:0];
         2'd1:    byte_v = word_i[15:8];
         2'd2:    byte_v = word_i[23:16];
         default: byte_v = word_i[31:24];
      endcase
   end

   // Halfword select ignores lane_i[0]; a misaligned halfword still returns
   // the containing aligned halfword and only raises the flag.
   assign half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      data_o     = 32'd0;
      misalign_o = 1'b0;
      case (op_i)
         OP_LB:  data_o = {{24{byte_v[7]}}, byte_v};
         OP_LBU: data_o = {24'd0, byte_v};
         OP_LH: begin
            data_o     = {{16{half_v[15]}}, half_v};
            misalign_o = lane_i[0];
         end
         OP_LHU: begin
            data_o     = {16'd0, half_v};
            misalign_o = lane_i[0];
         end
         OP_LW: begin
            data_o     = word_i;
            misalign_o = |lane_i;
         end
         default: begin
            data_o     = 32'd0;
            misalign_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
// Load path of the multicycle CPU (replaces the plain MDR). Accepts a load
// request, issues a word read, waits for the memory handshake (bounded by
// TIMEOUT_CYCLES) and registers the extended byte/halfword/word result.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start, op,     request strobe, opcode [31:26] and byte address;
//   addr           sampled only in IDLE
//   busy           state is not IDLE
//   done           one-cycle completion pulse
//   rdata          extended result, held until the next completion
//   align_err      misaligned access flag (data still returned)
//   bus_err        memory did not answer within TIMEOUT_CYCLES
//   mem_re         read request, high for the whole WAIT state
//   mem_addr       word-aligned read address
//   mem_ready      memory response valid
//   mem_rdata      memory read word
// TIMEOUT_CYCLES must be < 2**CNT_W.
// -----------------------------------------------------------------------------
module load_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        align_err,
   output logic        bus_err,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q;
   logic [5:0]        op_q;
   logic [31:0]       addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              busy_q;
   logic              done_q;
   logic              mem_re_q;
   logic [31:0]       rdata_q;
   logic              align_err_q;
   logic              bus_err_q;

   logic [31:0]       ext_data;
   logic              ext_misalign;

   load_extract u_extract (
      .op_i       (op_q),
      .lane_i     (addr_q[1:0]),
      .word_i     (mem_rdata),
      .data_o     (ext_data),
      .misalign_o (ext_misalign)
   );

   assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 6'd0;
         addr_q      <= 32'd0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         rdata_q     <= 32'd0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && is_load_op(op)) begin
                  op_q        <= op;
                  addr_q      <= addr;
                  cnt_q       <= '0;
                  align_err_q <= 1'b0;
                  bus_err_q   <= 1'b0;
                  busy_q      <= 1'b1;
                  mem_re_q    <= 1'b1;
                  state_q     <= WAIT;
               end
            end

            WAIT: begin
               cnt_q <= cnt_d;
               // A response in the final counted cycle still wins over timeout.
               if (mem_ready) begin
                  rdata_q     <= ext_data;
                  align_err_q <= ext_misalign;
                  mem_re_q    <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else if (cnt_q == CNT_LAST) begin
                  rdata_q     <= 32'd0;
                  bus_err_q   <= 1'b1;
                  align_err_q <= ext_misalign;
                  mem_re_q    <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end

            DONE: begin
               // start is deliberately not sampled here.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               done_q   <= 1'b0;
               busy_q   <= 1'b0;
               mem_re_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_re    = mem_re_q;
   assign rdata     = rdata_q;
   assign align_err = align_err_q;
   assign bus_err   = bus_err_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};

endmodule
